rom_region_loader: RTL and testbench

Parametrised successor to the fixed-layout download selector. It takes the byte-wide ioctl download stream and decodes each byte against a parameter table of up to NUM_REGIONS address windows. Bytes are packed little-endian into WORD_BYTES-wide words, and the block issues one registered write per word to the addressed region's ROM/PROM. It also counts bytes per region, flags out-of-range addresses, and asserts ROM_READY only after a complete, error-free download.

---
 rtl/rom_region_loader_pkg.sv | 24 ++
 rtl/rom_region_loader_if.sv | 30 +++
 rtl/rom_word_packer.sv | 104 ++++++++++
 rtl/rom_region_loader.sv | 121 ++++++++++++
 tb/tb_rom_region_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_region_loader_pkg.sv
// Shared types and helpers for the ROM region loader and its word packer.
package rom_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   // Inclusive base, exclusive limit; computed one bit wider so base+size cannot wrap.
   function automatic logic region_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
      logic [32:0] lim;
      lim = {1'b0, base} + {1'b0, size};
      return (size != '0) && ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
   endfunction

   // ceil(log2(n)), never below 1 so single-entry selects still get a real bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/rom_region_loader_if.sv
// ioctl download stream in, region write port and status out.
interface rom_region_loader_if #(
   parameter int NUM_REGIONS = 8,
   parameter int ADDR_W      = 25,
   parameter int WORD_BYTES  = 1,
   parameter int OFFS_W      = 15
);
   logic                    ioctl_download;
   logic [7:0]              ioctl_index;
   logic                    ioctl_wr;
   logic [ADDR_W-1:0]       ioctl_addr;
   logic [7:0]              ioctl_dout;
   logic [NUM_REGIONS-1:0]  WR_EN;
   logic [OFFS_W-1:0]       WR_ADDR;
   logic [8*WORD_BYTES-1:0] WR_DATA;
   logic [WORD_BYTES-1:0]   WR_BE;
   logic                    BUSY;
   logic                    ROM_READY;
   logic                    ERR_OOR;
   logic [NUM_REGIONS-1:0]  ERR_SHORT;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  WR_EN, WR_ADDR, WR_DATA, WR_BE, BUSY, ROM_READY, ERR_OOR, ERR_SHORT
   );
   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output WR_EN, WR_ADDR, WR_DATA, WR_BE, BUSY, ROM_READY, ERR_OOR, ERR_SHORT
   );
endinterface

// File: rtl/rom_word_packer.sv
// Packs decoded bytes little-endian into words and issues one registered write per word.
module rom_word_packer
   import rom_loader_pkg::*;
#(
   parameter int NUM_REGIONS = 8,
   parameter int WORD_BYTES  = 1,
   parameter int OFFS_W      = 15,
   localparam int RW = clog2_min1(NUM_REGIONS),
   localparam int LW = clog2_min1(WORD_BYTES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    flush,
   input  logic                    byte_vld,
   input  logic [RW-1:0]           byte_region,
   input  logic [OFFS_W-1:0]       byte_word,
   input  logic [LW-1:0]           byte_lane,
   input  logic [7:0]              byte_data,
   output logic [NUM_REGIONS-1:0]  wr_en,
   output logic [OFFS_W-1:0]       wr_addr,
   output logic [8*WORD_BYTES-1:0] wr_data,
   output logic [WORD_BYTES-1:0]   wr_be
);
   typedef struct packed {
      logic [RW-1:0]           region;
      logic [OFFS_W-1:0]       word;
      logic [8*WORD_BYTES-1:0] data;
      logic [WORD_BYTES-1:0]   be;
   } word_t;

   word_t buf_q, buf_d, emit_w, merged;
   logic  buf_vld_q, buf_vld_d, buf_full_q, buf_full_d, emit;

   // One write per cycle: if a discontinuity flush and a completed fresh word collide,
   // the fresh word is parked as full and goes out on the following cycle.
   always_comb begin
      emit       = 1'b0;
      emit_w     = buf_q;
      buf_d      = buf_q;
      buf_vld_d  = buf_vld_q;
      buf_full_d = buf_full_q;
      if (buf_vld_q && (buf_full_q || flush ||
          (byte_vld && (buf_q.region != byte_region || buf_q.word != byte_word)))) begin
         emit       = 1'b1;
         buf_vld_d  = 1'b0;
         buf_full_d = 1'b0;
      end
      merged        = buf_vld_d ? buf_q : '0;
      merged.region = byte_region;
      merged.word   = byte_word;
      for (int l = 0; l < WORD_BYTES; l++) begin
         if (byte_lane == LW'(l)) begin
            merged.data[8*l +: 8] = byte_data;
            merged.be[l]          = 1'b1;
         end
      end
      if (byte_vld) begin
         if (byte_lane == LW'(WORD_BYTES - 1)) begin
            if (emit) begin
               buf_d      = merged;
               buf_vld_d  = 1'b1;
               buf_full_d = 1'b1;
            end else begin
               emit      = 1'b1;
               emit_w    = merged;
               buf_vld_d = 1'b0;
            end
         end else begin
            buf_d     = merged;
            buf_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         buf_vld_q  <= 1'b0;
         buf_full_q <= 1'b0;
         wr_en      <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_be      <= '0;
      end else begin
         wr_en <= '0;
         if (clear) begin
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_full_q <= 1'b0;
         end else begin
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            buf_full_q <= buf_full_d;
            if (emit) begin
               wr_en   <= NUM_REGIONS'(1) << emit_w.region;
               wr_addr <= emit_w.word;
               wr_data <= emit_w.data;
               wr_be   <= emit_w.be;
            end
         end
      end
   end
endmodule

// File: rtl/rom_region_loader.sv
// Decodes the ioctl byte stream against a region table, counts bytes per region and
// reports download completeness; word packing and write output live in rom_word_packer.
module rom_region_loader
   import rom_loader_pkg::*;
#(
   parameter int NUM_REGIONS = 8,
   parameter int ADDR_W      = 25,
   parameter int WORD_BYTES  = 1,
   parameter int OFFS_W      = 15,
   parameter logic [7:0] INDEX = 8'd0,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
      {25'h28400, 25'h28200, 25'h28000, 25'h20000, 25'h18000, 25'h10000, 25'h08000, 25'h00000},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE =
      {25'h200, 25'h200, 25'h200, 25'h8000, 25'h8000, 25'h8000, 25'h8000, 25'h8000}
) (
   input logic CLK,
   input logic RESET_N,
   rom_region_loader_if.slave bus
);
   localparam int RW    = clog2_min1(NUM_REGIONS);
   localparam int LW    = clog2_min1(WORD_BYTES);
   localparam int SHIFT = $clog2(WORD_BYTES);

   state_t                             state;
   logic                               dl_q, busy, rom_ready, err_oor;
   logic [NUM_REGIONS-1:0]             err_short, short_c;
   logic [NUM_REGIONS-1:0][ADDR_W-1:0] cnt;
   logic                               idx_ok, rise, start, acc, hit;
   logic [RW-1:0]                      hit_idx;
   logic [ADDR_W-1:0]                  rel;

   assign idx_ok = bus.ioctl_index == INDEX;
   assign rise   = bus.ioctl_download && !dl_q && idx_ok;
   assign start  = rise && (state == IDLE || state == DONE);
   assign acc    = (state == LOAD) && bus.ioctl_wr && idx_ok;

   // Scan high to low so the lowest matching region is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      rel     = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (region_hit(32'(bus.ioctl_addr), 32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                        32'(REGION_SIZE[i*ADDR_W +: ADDR_W]))) begin
            hit     = 1'b1;
            hit_idx = RW'(i);
            rel     = bus.ioctl_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      short_c = '0;
      for (int i = 0; i < NUM_REGIONS; i++)
         short_c[i] = (REGION_SIZE[i*ADDR_W +: ADDR_W] != '0) &&
                      (cnt[i] != REGION_SIZE[i*ADDR_W +: ADDR_W]);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         dl_q      <= 1'b0;
         busy      <= 1'b0;
         rom_ready <= 1'b0;
         err_oor   <= 1'b0;
         err_short <= '0;
         cnt       <= '0;
      end else begin
         dl_q <= bus.ioctl_download;
         case (state)
            IDLE, DONE: if (start) begin
               state     <= LOAD;
               busy      <= 1'b1;
               rom_ready <= 1'b0;
               err_oor   <= 1'b0;
               err_short <= '0;
               cnt       <= '0;
            end
            LOAD: begin
               if (acc && !hit) err_oor <= 1'b1;
               for (int i = 0; i < NUM_REGIONS; i++)
                  if (acc && hit && hit_idx == RW'(i) && cnt[i] != '1)
                     cnt[i] <= cnt[i] + 1'b1;
               if (!bus.ioctl_download) state <= FLUSH;
            end
            FLUSH: begin
               err_short <= short_c;
               rom_ready <= !err_oor && (short_c == '0);
               busy      <= 1'b0;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.BUSY      = busy;
   assign bus.ROM_READY = rom_ready;
   assign bus.ERR_OOR   = err_oor;
   assign bus.ERR_SHORT = err_short;

   rom_word_packer #(
      .NUM_REGIONS(NUM_REGIONS),
      .WORD_BYTES (WORD_BYTES),
      .OFFS_W     (OFFS_W)
   ) u_pack (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .clear      (start),
      .flush      (state == FLUSH),
      .byte_vld   (acc && hit),
      .byte_region(hit_idx),
      .byte_word  (OFFS_W'(rel >> SHIFT)),
      .byte_lane  (LW'(rel & ADDR_W'(WORD_BYTES - 1))),
      .byte_data  (bus.ioctl_dout),
      .wr_en      (bus.WR_EN),
      .wr_addr    (bus.WR_ADDR),
      .wr_data    (bus.WR_DATA),
      .wr_be      (bus.WR_BE)
   );
endmodule

// File: tb/tb_rom_region_loader.sv
// Three loaders (WORD_BYTES 1/2/4) share one ioctl stream over a 1/16-scale Arkanoid layout;
// a byte-level reference model queues the expected writes for each.
module tb_rom_region_loader;
   localparam logic [199:0] BASES =
      {25'h2840, 25'h2820, 25'h2800, 25'h2000, 25'h1800, 25'h1000, 25'h0800, 25'h0000};
   localparam logic [199:0] SIZES =
      {25'h20, 25'h20, 25'h20, 25'h800, 25'h800, 25'h800, 25'h800, 25'h800};
   localparam int TOTAL = 'h2860;

   typedef struct packed {
      logic [7:0]  en;
      logic [14:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic        CLK, rst_n, dl, wr;
   logic [7:0]  idx, dout;
   logic [24:0] addr;
   int          n_chk, n_fail;

   rom_region_loader_if #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(1), .OFFS_W(15)) if1 ();
   rom_region_loader_if #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(2), .OFFS_W(15)) if2 ();
   rom_region_loader_if #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(4), .OFFS_W(15)) if4 ();

   assign if1.ioctl_download = dl; assign if1.ioctl_index = idx; assign if1.ioctl_wr = wr;
   assign if1.ioctl_addr = addr;   assign if1.ioctl_dout = dout;
   assign if2.ioctl_download = dl; assign if2.ioctl_index = idx; assign if2.ioctl_wr = wr;
   assign if2.ioctl_addr = addr;   assign if2.ioctl_dout = dout;
   assign if4.ioctl_download = dl; assign if4.ioctl_index = idx; assign if4.ioctl_wr = wr;
   assign if4.ioctl_addr = addr;   assign if4.ioctl_dout = dout;

   rom_region_loader #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(1), .OFFS_W(15), .INDEX(8'd0),
      .REGION_BASE(BASES), .REGION_SIZE(SIZES)) u_wb1 (.CLK(CLK), .RESET_N(rst_n), .bus(if1));
   rom_region_loader #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(2), .OFFS_W(15), .INDEX(8'd0),
      .REGION_BASE(BASES), .REGION_SIZE(SIZES)) u_wb2 (.CLK(CLK), .RESET_N(rst_n), .bus(if2));
   rom_region_loader #(.NUM_REGIONS(8), .ADDR_W(25), .WORD_BYTES(4), .OFFS_W(15), .INDEX(8'd0),
      .REGION_BASE(BASES), .REGION_SIZE(SIZES)) u_wb4 (.CLK(CLK), .RESET_N(rst_n), .bus(if4));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   int          bases[8], sizes[8];
   logic        m_active;
   logic        m_vld[3];
   int          m_reg[3], m_word[3];
   logic [31:0] m_data[3];
   logic [3:0]  m_be[3];
   wr_t         q0[$], q1[$], q2[$];

   task automatic model_emit(input int k);
      wr_t e;
      e.en = 8'(1 << m_reg[k]); e.addr = 15'(m_word[k]); e.data = m_data[k]; e.be = m_be[k];
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
      m_vld[k] = 1'b0;
   endtask

   task automatic model_byte(input int a, input logic [7:0] d);
      int r, wb, rel, w, l;
      r = -1;
      for (int i = 7; i >= 0; i--) if (a >= bases[i] && a < bases[i] + sizes[i]) r = i;
      if (r >= 0) begin
         for (int k = 0; k < 3; k++) begin
            wb = 1 << k; rel = a - bases[r]; w = rel / wb; l = rel % wb;
            if (m_vld[k] && (m_reg[k] != r || m_word[k] != w)) model_emit(k);
            if (!m_vld[k]) begin
               m_data[k] = '0; m_be[k] = '0; m_reg[k] = r; m_word[k] = w; m_vld[k] = 1'b1;
            end
            m_data[k][8*l +: 8] = d;
            m_be[k][l]          = 1'b1;
            if (l == wb - 1) model_emit(k);
         end
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++) m_vld[k] = 1'b0;
   endtask

   always @(negedge CLK) begin : mon1
      wr_t o, e;
      if (if1.WR_EN != '0) begin
         o = '{en: if1.WR_EN, addr: if1.WR_ADDR, data: 32'(if1.WR_DATA), be: 4'(if1.WR_BE)};
         if (q0.size() == 0) chk("wb1_extra_wr", 64'(o), 64'd0);
         else begin e = q0.pop_front(); chk("wb1_wr", 64'(o), 64'(e)); end
      end
   end
   always @(negedge CLK) begin : mon2
      wr_t o, e;
      if (if2.WR_EN != '0) begin
         o = '{en: if2.WR_EN, addr: if2.WR_ADDR, data: 32'(if2.WR_DATA), be: 4'(if2.WR_BE)};
         if (q1.size() == 0) chk("wb2_extra_wr", 64'(o), 64'd0);
         else begin e = q1.pop_front(); chk("wb2_wr", 64'(o), 64'(e)); end
      end
   end
   always @(negedge CLK) begin : mon4
      wr_t o, e;
      if (if4.WR_EN != '0) begin
         o = '{en: if4.WR_EN, addr: if4.WR_ADDR, data: 32'(if4.WR_DATA), be: 4'(if4.WR_BE)};
         if (q2.size() == 0) chk("wb4_extra_wr", 64'(o), 64'd0);
         else begin e = q2.pop_front(); chk("wb4_wr", 64'(o), 64'(e)); end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) begin @(negedge CLK); wr = 1'b0; end
   endtask

   task automatic start(input logic [7:0] i);
      @(negedge CLK);
      wr = 1'b0; dl = 1'b1; idx = i;
      m_active = (i == 8'd0);
      model_clear();
   endtask

   task automatic put(input int a, input logic [7:0] d);
      @(negedge CLK);
      wr = 1'b1; addr = 25'(a); dout = d;
      if (m_active) model_byte(a, d);
   endtask

   task automatic stop();
      @(negedge CLK);
      wr = 1'b0; dl = 1'b0;
      if (m_active) for (int k = 0; k < 3; k++) if (m_vld[k]) model_emit(k);
      m_active = 1'b0;
   endtask

   function automatic logic [7:0] pat(input int a);
      return 8'(a ^ (a >> 8) ^ 'h5A);
   endfunction

   // {BUSY, ROM_READY, ERR_OOR, ERR_SHORT} on all three loaders
   task automatic status_all(input string tag, input logic [10:0] exp);
      chk({tag, "_wb1"}, {if1.BUSY, if1.ROM_READY, if1.ERR_OOR, if1.ERR_SHORT}, 64'(exp));
      chk({tag, "_wb2"}, {if2.BUSY, if2.ROM_READY, if2.ERR_OOR, if2.ERR_SHORT}, 64'(exp));
      chk({tag, "_wb4"}, {if4.BUSY, if4.ROM_READY, if4.ERR_OOR, if4.ERR_SHORT}, 64'(exp));
   endtask

   task automatic full_download(input string tag);
      start(8'd0);
      for (int a = 0; a < TOTAL; a++) begin
         put(a, pat(a));
         if (a == 'h100) chk({tag, "_busy_load"}, 64'(if1.BUSY), 64'd1);
         if (a == 'h2801) begin
            chk({tag, "_r5_en"}, 64'(if1.WR_EN), 64'h20);
            chk({tag, "_r5_addr"}, 64'(if1.WR_ADDR), 64'd0);
         end
      end
      stop();
      wait_cyc(4);
      status_all(tag, {1'b0, 1'b1, 1'b0, 8'h00});
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      dl = 1'b0; wr = 1'b0; idx = 8'd0; addr = '0; dout = '0; m_active = 1'b0;
      model_clear();
      for (int i = 0; i < 8; i++) begin
         bases[i] = (i < 5) ? i * 'h800 : 'h2800 + (i - 5) * 'h20;
         sizes[i] = (i < 5) ? 'h800 : 'h20;
      end
      rst_n = 1'b0;
      #3;
      chk("rst_wb1", {if1.BUSY, if1.ROM_READY, if1.ERR_OOR, if1.ERR_SHORT, if1.WR_EN}, 64'd0);
      chk("rst_wb2", {if2.BUSY, if2.ROM_READY, if2.ERR_OOR, if2.ERR_SHORT, if2.WR_EN}, 64'd0);
      chk("rst_wb4", {if4.BUSY, if4.ROM_READY, if4.ERR_OOR, if4.ERR_SHORT, if4.WR_EN}, 64'd0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);

      full_download("full");

      // foreign index: nothing written, state untouched
      start(8'd1);
      for (int a = 0; a < 4; a++) put(a, 8'hC0 + 8'(a));
      wait_cyc(2);
      chk("idx1_busy", 64'(if1.BUSY), 64'd0);
      stop();
      wait_cyc(3);
      status_all("idx1", {1'b0, 1'b1, 1'b0, 8'h00});

      // word packing, discontinuity and flush
      start(8'd0);
      put(0, 8'h11);
      put(1, 8'h22);
      wait_cyc(1);
      chk("wb2_pair_en", 64'(if2.WR_EN), 64'h01);
      chk("wb2_pair_data", 64'(if2.WR_DATA), 64'h2211);
      chk("wb2_pair_be", 64'(if2.WR_BE), 64'h3);
      chk("wb2_pair_addr", 64'(if2.WR_ADDR), 64'd0);
      put('h4, 8'hAA);
      put('h10, 8'hBB);
      wait_cyc(1);
      chk("wb4_disc", {if4.WR_EN, if4.WR_ADDR, if4.WR_DATA, if4.WR_BE},
          {8'h01, 15'd1, 32'h0000_00AA, 4'b0001});
      stop();
      wait_cyc(2);
      chk("wb4_flush", {if4.WR_EN, if4.WR_ADDR, if4.WR_DATA, if4.WR_BE},
          {8'h01, 15'd4, 32'h0000_00BB, 4'b0001});
      wait_cyc(2);
      status_all("pack", {1'b0, 1'b0, 1'b0, 8'hFF});

      // zero-byte download clears the previous errors and flags every region short
      start(8'd0);
      stop();
      wait_cyc(3);
      status_all("zero", {1'b0, 1'b0, 1'b0, 8'hFF});

      // short download plus an out-of-range byte
      start(8'd0);
      for (int a = 0; a < 'h2800; a++) put(a, pat(a));
      put('h3000, 8'h77);
      stop();
      wait_cyc(4);
      status_all("short", {1'b0, 1'b0, 1'b1, 8'hE0});

      // reset with a half-filled word pending
      start(8'd0);
      put(2, 8'h55);
      wait_cyc(1);
      chk("mid_busy", 64'(if2.BUSY), 64'd1);
      #2;
      rst_n = 1'b0;
      dl = 1'b0;
      m_active = 1'b0;
      model_clear();
      #1;
      chk("mid_rst_wb2", {if2.BUSY, if2.ROM_READY, if2.ERR_OOR, if2.ERR_SHORT, if2.WR_EN}, 64'd0);
      chk("mid_rst_wb4", {if4.BUSY, if4.ROM_READY, if4.ERR_OOR, if4.ERR_SHORT, if4.WR_EN}, 64'd0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(3);
      full_download("after_rst");

      chk("q_left_wb1", 64'(q0.size()), 64'd0);
      chk("q_left_wb2", 64'(q1.size()), 64'd0);
      chk("q_left_wb4", 64'(q2.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
